// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the multiply/divide engine.
package muldiv_unit_pkg;

  // Iteration counter width; must hold WIDTH-1.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/define_alu_ctrl.vh
// Shared ALU control codes emitted by the decoder (SIG_ALU_*).
// Included by every execute-stage consumer of alucontrol.
`ifndef DEFINE_ALU_CTRL_VH
`define DEFINE_ALU_CTRL_VH

`define SIG_ALU_AND    5'd0
`define SIG_ALU_OR     5'd1
`define SIG_ALU_ADD    5'd2
`define SIG_ALU_SUB    5'd6
`define SIG_ALU_SLT    5'd7
`define SIG_ALU_MULT   5'd16
`define SIG_ALU_MULTU  5'd17
`define SIG_ALU_DIV    5'd18
`define SIG_ALU_DIVU   5'd19

`endif

// File: rtl/muldiv_unit_div_radix2_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the result
// only when it does not go negative.
module div_radix2_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; the extra top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_i, quo_msb_i};
    diff    = {1'b0, shifted} - {2'b00, dvs_i};
    qbit_o  = ~diff[WIDTH+1];
    rem_o   = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing the {HI,LO} pair.
// Signed operations iterate on magnitudes and fix signs at the end.
// Optional build macro: MULDIV_FAST_MULT_EN -- multiplies complete in a
// single cycle with a native multiplier; division always iterates.
`include "define_alu_ctrl.vh"

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [4:0]       alucontrol_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + 1'b1;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operation latched at accept
  op_t              op_q;
  logic             neg_q;   // negate quotient / product
  logic             rneg_q;  // negate remainder (dividend sign)
  logic             dz_q;    // divide by zero
  logic [WIDTH-1:0] srca_q;
  logic [WIDTH-1:0] opb_q;   // divisor or multiplicand magnitude
  logic [WIDTH-1:0] acc_hi;  // remainder or product upper half
  logic [WIDTH-1:0] acc_lo;  // dividend/quotient or multiplier/product lower half

  logic             is_md, is_div, is_sgn, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, fin_hi, fin_lo;

  assign busy_o = (state != ST_IDLE);

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    is_div = (alucontrol_i == `SIG_ALU_DIV)  || (alucontrol_i == `SIG_ALU_DIVU);
    is_sgn = (alucontrol_i == `SIG_ALU_DIV)  || (alucontrol_i == `SIG_ALU_MULT);
    is_md  = is_div || (alucontrol_i == `SIG_ALU_MULT) || (alucontrol_i == `SIG_ALU_MULTU);
    accept = (state == ST_IDLE) && start_i && is_md && !cancel_i;
    a_neg  = is_sgn && srca_i[WIDTH-1];
    b_neg  = is_sgn && srcb_i[WIDTH-1];
    mag_a  = a_neg ? neg_w(srca_i) : srca_i;
    mag_b  = b_neg ? neg_w(srcb_i) : srcb_i;
  end

  div_radix2_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (acc_hi),
    .quo_msb_i (acc_lo[WIDTH-1]),
    .dvs_i     (opb_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // One iteration of the selected algorithm, plus final sign fix-up
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    if (op_q == OP_DIV) begin
      nxt_hi = step_rem;
      nxt_lo = {acc_lo[WIDTH-2:0], step_qbit};
      if (dz_q) begin
        fin_hi = srca_q;
        fin_lo = '1;
      end else begin
        fin_hi = rneg_q ? neg_w(nxt_hi) : nxt_hi;
        fin_lo = neg_q  ? neg_w(nxt_lo) : nxt_lo;
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      {fin_hi, fin_lo} = neg_q ? neg_2w({nxt_hi, nxt_lo}) : {nxt_hi, nxt_lo};
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic signed [2*WIDTH-1:0] fast_prod;

  // Single-cycle product; the extra top bit selects signed/unsigned extension
  always_comb begin
    fast_prod = $signed({a_neg, srca_i}) * $signed({b_neg, srcb_i});
  end
`endif

  // Control FSM with registered done/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (cancel_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (accept) begin
`ifdef MULDIV_FAST_MULT_EN
              if (!is_div) begin
                hi_o   <= fast_prod[2*WIDTH-1:WIDTH];
                lo_o   <= fast_prod[WIDTH-1:0];
                done_o <= 1'b1;
                state  <= ST_DONE;
              end else begin
                state <= ST_CALC;
              end
`else
              state <= ST_CALC;
`endif
            end
          end
          ST_CALC: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              hi_o   <= fin_hi;
              lo_o   <= fin_lo;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath registers: load operands on accept, iterate while calculating
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= is_div ? OP_DIV : OP_MUL;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= is_div && (srcb_i == '0);
      srca_q <= srca_i;
      acc_hi <= '0;
      acc_lo <= is_div ? mag_a : mag_b;
      opb_q  <= is_div ? mag_b : mag_a;
    end else if (state == ST_CALC) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [4:0] C_AND = 5'd0, C_OR = 5'd1, C_ADD = 5'd2, C_SUB = 5'd6,
                         C_SLT = 5'd7, C_MULT = 5'd16, C_MULTU = 5'd17,
                         C_DIV = 5'd18, C_DIVU = 5'd19;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ctl = C_ADD;
  logic [31:0] a = '0, b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .alucontrol_i (ctl),
    .srca_i       (a),
    .srcb_i       (b),
    .cancel_i     (cancel),
    .busy_o       (busy),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  function automatic int exp_lat(input logic [4:0] op);
    return (op == C_MULT || op == C_MULTU) ? MUL_LAT : DIV_LAT;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definitions
  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    eh = '0;
    el = '0;
    case (op)
      C_MULT:  begin q = sx * sy; eh = q[63:32]; el = q[31:0]; end
      C_MULTU: begin uq = ux * uy; eh = uq[63:32]; el = uq[31:0]; end
      C_DIV: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin q = sx / sy; r = sx % sy; eh = r[31:0]; el = q[31:0]; end
      end
      C_DIVU: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin uq = ux / uy; ur = ux % uy; eh = ur[31:0]; el = uq[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Issue one operation and wait (bounded) for done; lat=-1 on timeout
  task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic busy_ok,
                       output logic [31:0] gh, output logic [31:0] gl);
    @(negedge clk);
    start = 1'b1; ctl = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; ctl = C_ADD;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    if (done !== 1'b1) lat = -1;
    gh = hi;
    gl = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; ctl = C_AND; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0; ctl = C_ADD;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL and_ignored_busy got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL and_ignored_idle got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_divu();
    int lat; logic bok; logic [31:0] gh, gl;
    do_op(C_DIVU, 32'd100, 32'd7, lat, bok, gh, gl);
    total++; if (lat != 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL divu_busy got=%b exp=1", bok); end
    total++; if (gl !== 32'h0000000E) begin bad++; $display("FAIL divu_lo got=%h exp=0000000e", gl); end
    total++; if (gh !== 32'h00000002) begin bad++; $display("FAIL divu_hi got=%h exp=00000002", gh); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL divu_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_div_signed();
    int lat; logic bok; logic [31:0] gh, gl;
    do_op(C_DIV, 32'h00000007, 32'hFFFFFFFE, lat, bok, gh, gl);
    total++; if (gl !== 32'hFFFFFFFD || gh !== 32'h00000001) begin
      bad++; $display("FAIL div_7_m2 got=%h_%h exp=00000001_fffffffd", gh, gl);
    end
    do_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bok, gh, gl);
    total++; if (gl !== 32'h80000000 || gh !== 32'h0) begin
      bad++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", gh, gl);
    end
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL div_ovf_latency got=%0d exp=%0d", lat, DIV_LAT); end
  endtask

  task automatic test_mult();
    int lat; logic bok; logic [31:0] gh, gl;
    do_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok, gh, gl);
    total++; if (gh !== 32'hFFFFFFFE || gl !== 32'h00000001) begin
      bad++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", gh, gl);
    end
    total++; if (lat != MUL_LAT) begin bad++; $display("FAIL multu_latency got=%0d exp=%0d", lat, MUL_LAT); end
    do_op(C_MULT, 32'hFFFFFFFF, 32'd2, lat, bok, gh, gl);
    total++; if (gh !== 32'hFFFFFFFF || gl !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL mult_m1x2 got=%h_%h exp=ffffffff_fffffffe", gh, gl);
    end
    total++; if (lat != MUL_LAT) begin bad++; $display("FAIL mult_latency got=%0d exp=%0d", lat, MUL_LAT); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL mult_busy got=%b exp=1", bok); end
  endtask

  task automatic test_divzero();
    int lat; logic bok; logic [31:0] gh, gl;
    do_op(C_DIVU, 32'd5, 32'd0, lat, bok, gh, gl);
    total++; if (gl !== 32'hFFFFFFFF || gh !== 32'h00000005) begin
      bad++; $display("FAIL divu_by0 got=%h_%h exp=00000005_ffffffff", gh, gl);
    end
    total++; if (lat != 33) begin bad++; $display("FAIL divu_by0_latency got=%0d exp=33", lat); end
    do_op(C_DIV, 32'hFFFFFFFB, 32'd0, lat, bok, gh, gl);
    total++; if (gl !== 32'hFFFFFFFF || gh !== 32'hFFFFFFFB) begin
      bad++; $display("FAIL div_by0_neg got=%h_%h exp=fffffffb_ffffffff", gh, gl);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] ph, pl;
    logic seen_done;
    ph = hi; pl = lo;
    @(negedge clk);
    start = 1'b1; ctl = C_DIV; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0; ctl = C_ADD;
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cancel_busy_before got=%b exp=1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy_after got=%b exp=0", busy); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL cancel_no_done got=%b exp=0", seen_done); end
    total++; if (hi !== ph || lo !== pl) begin
      bad++; $display("FAIL cancel_hold got=%h_%h exp=%h_%h", hi, lo, ph, pl);
    end
    // cancel wins over start in the same cycle
    start = 1'b1; cancel = 1'b1; ctl = C_DIVU; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; ctl = C_ADD;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_prio got=%b exp=0", busy); end
  endtask

  task automatic test_start_during_calc();
    int lat; int dones;
    @(negedge clk);
    start = 1'b1; ctl = C_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; ctl = C_ADD;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin start = 1'b1; ctl = C_DIV; a = 32'hFFFFFF00; b = 32'd9; end
      else if (lat == 6) begin start = 1'b0; ctl = C_ADD; end
      @(negedge clk);
      lat++;
    end
    total++; if (lat != 33) begin bad++; $display("FAIL calc_start_latency got=%0d exp=33", lat); end
    total++; if (lo !== 32'd333 || hi !== 32'd1) begin
      bad++; $display("FAIL calc_start_result got=%h_%h exp=00000001_0000014d", hi, lo);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL calc_start_no_queue got=%0d exp=0", dones); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; ctl = C_DIVU; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0; ctl = C_ADD;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h exp 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int l1, l2; logic b1, b2; logic [31:0] h1, g1, h2, g2, eh, el;
    do_op(C_DIVU, 32'd12345, 32'd100, l1, b1, h1, g1);
    do_op(C_MULT, 32'hFFFFFFF0, 32'd300, l2, b2, h2, g2);
    total++; if (g1 !== 32'd123 || h1 !== 32'd45) begin
      bad++; $display("FAIL b2b_first got=%h_%h exp=0000002d_0000007b", h1, g1);
    end
    model(C_MULT, 32'hFFFFFFF0, 32'd300, eh, el);
    total++; if (h2 !== eh || g2 !== el || l2 != MUL_LAT) begin
      bad++; $display("FAIL b2b_second got=%h_%h lat=%0d exp=%h_%h lat=%0d", h2, g2, l2, eh, el, MUL_LAT);
    end
  endtask

  task automatic test_random();
    logic [4:0] codes [9];
    logic [4:0] op;
    logic [31:0] x, y, eh, el, gh, gl;
    int lat; logic bok;
    codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_MULT, C_MULTU, C_DIV, C_DIVU};
    for (int i = 0; i < 24; i++) begin
      op = codes[$urandom_range(8)];
      case ($urandom_range(3))
        0: x = $urandom;
        1: x = $urandom_range(50);
        2: x = 32'h80000000 | $urandom_range(3);
        default: x = -($urandom_range(1000));
      endcase
      case ($urandom_range(3))
        0: y = $urandom;
        1: y = $urandom_range(20);
        2: y = 32'hFFFFFFFF - $urandom_range(2);
        default: y = $urandom_range(65535);
      endcase
      if (op == C_MULT || op == C_MULTU || op == C_DIV || op == C_DIVU) begin
        do_op(op, x, y, lat, bok, gh, gl);
        model(op, x, y, eh, el);
        total++; if (gh !== eh || gl !== el || lat != exp_lat(op) || bok !== 1'b1) begin
          bad++;
          $display("FAIL rand_%0d op=%0d a=%h b=%h got=%h_%h lat=%0d busy=%b exp=%h_%h lat=%0d",
                   i, op, x, y, gh, gl, lat, bok, eh, el, exp_lat(op));
        end
      end else begin
        @(negedge clk);
        start = 1'b1; ctl = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; ctl = C_ADD;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
          bad++; $display("FAIL rand_%0d other_code=%0d got busy=%b done=%b exp 0/0", i, op, busy, done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_mult();
    test_divzero();
    test_cancel();
    test_start_during_calc();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
